// File: rtl/i2c_sipo_receiver.sv
// i2c_sipo_receiver: oversampled I2C-style byte receiver.
// SCL/SDA are synchronized, and edge/condition events are registered once
// before they reach the FSM. Bytes are assembled MSB first on SCL rising
// edges. ACK/NACK is driven in the 9th bit through an open-drain enable.
module i2c_sipo_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic       ack_en,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy,
  output logic       sda_oe
);

  typedef enum logic [1:0] {IDLE, DATA, ACK} state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_s, sda_s;
  logic                   scl_d_q, sda_d_q;
  logic                   rise_ev_q, fall_ev_q, start_ev_q, stop_ev_q, bit_q;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        full_q, full_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        start_det_q, start_det_d;
  logic        stop_det_q, stop_det_d;
  logic        sda_oe_q, sda_oe_d;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Synchronizer chains; they reset to 1 so that reset looks like an idle bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_d_q    <= 1'b1;
      sda_d_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_d_q    <= scl_s;
      sda_d_q    <= sda_s;
    end
  end

  // Register the bus events, together with the SDA value that goes with them.
  // START/STOP require SCL high in both samples, so they never coincide with
  // an SCL edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_ev_q  <= 1'b0;
      fall_ev_q  <= 1'b0;
      start_ev_q <= 1'b0;
      stop_ev_q  <= 1'b0;
      bit_q      <= 1'b1;
    end else begin
      rise_ev_q  <= scl_s & ~scl_d_q;
      fall_ev_q  <= ~scl_s & scl_d_q;
      start_ev_q <= scl_s & scl_d_q & sda_d_q & ~sda_s;
      stop_ev_q  <= scl_s & scl_d_q & ~sda_d_q & sda_s;
      bit_q      <= sda_s;
    end
  end

  // FSM and datapath state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      full_q      <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      full_q      <= full_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  // Next state. STOP and START override everything else and discard any
  // partial byte. full_q marks "8th rise seen, waiting for the falling edge
  // that opens the ACK bit".
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    full_d      = full_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    sda_oe_d    = sda_oe_q;

    if (stop_ev_q) begin
      stop_det_d = 1'b1;
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      shift_d    = 8'h00;
      full_d     = 1'b0;
      sda_oe_d   = 1'b0;
    end else if (start_ev_q) begin
      start_det_d = 1'b1;
      state_d     = DATA;
      bit_cnt_d   = 3'd0;
      shift_d     = 8'h00;
      full_d      = 1'b0;
      sda_oe_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end
        DATA: begin
          if (rise_ev_q) begin
            shift_d   = {shift_q[6:0], bit_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              data_d  = {shift_q[6:0], bit_q};
              valid_d = 1'b1;
              full_d  = 1'b1;
            end
          end else if (fall_ev_q && full_q) begin
            state_d  = ACK;
            sda_oe_d = ack_en;
            full_d   = 1'b0;
          end
        end
        ACK: begin
          if (fall_ev_q) begin
            sda_oe_d = 1'b0;
            state_d  = DATA;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign start_det  = start_det_q;
  assign stop_det   = stop_det_q;
  assign busy       = (state_q != IDLE);
  assign sda_oe     = sda_oe_q;

endmodule

// File: doc/i2c_sipo_receiver.md
Name: i2c_sipo_receiver

Overview:
- Receive side of the team's MSB-first 8-bit serial byte link: a serial-in/parallel-out I2C-style byte receiver.
- Oversamples raw SCL/SDA on the system clock and synchronizes them.
- Detects START, repeated START and STOP conditions.
- Assembles bytes MSB first on SCL rising edges, presents each completed byte in parallel, and drives the ACK/NACK bit through an open-drain enable.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each SCL/SDA synchronizer chain (min 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous reset, active low.
- scl_in  input  1  raw bus SCL, asynchronous to clk.
- sda_in  input  1  raw bus SDA, asynchronous to clk.
- ack_en  input  1  1 = ACK received bytes (pull SDA low in the 9th bit); 0 = NACK.
- data_out  output  8  last completed byte, MSB = first bit received.
- data_valid  output  1  one-cycle pulse when data_out is updated.
- start_det  output  1  one-cycle pulse on START or repeated START.
- stop_det  output  1  one-cycle pulse on STOP.
- busy  output  1  high while state != IDLE.
- sda_oe  output  1  1 = drive SDA low (open drain); 0 = release.

Behaviour:
- Reset (async, rst_n=0):
  - Synchronizer flops and the delayed samples reset to 1 (idle bus).
  - State IDLE, bit_cnt=0, shift_reg=0.
  - data_out=0; data_valid, start_det, stop_det, busy and sda_oe all 0.
  - Reset asserted mid-byte discards the partial byte and releases sda_oe immediately (asynchronously).
- Synchronizers and edge detection:
  - scl_s and sda_s are the outputs of the SYNC_STAGES-deep chains; scl_d and sda_d are scl_s and sda_s delayed one clk.
  - scl_rise = scl_s & ~scl_d; scl_fall = ~scl_s & scl_d.
  - START = scl_s & scl_d & sda_d & ~sda_s (SDA falls while SCL is high).
  - STOP = scl_s & scl_d & ~sda_d & sda_s (SDA rises while SCL is high).
  - A cycle with an SCL edge never counts as START or STOP.
  - Latency: a pin change captured at clk edge E0 produces its registered response (pulse, state change, sda_oe change) at edge E0+SYNC_STAGES+1.
- State machine (states IDLE, DATA, ACK):
  - IDLE: ignores SCL/SDA except START -> DATA, bit_cnt=0.
  - DATA, on scl_rise: shift_reg <= {shift_reg[6:0], sda_s}; bit_cnt+1.
    - On the 8th rise (bit_cnt==7): data_out <= assembled byte, data_valid=1 for 1 cycle, bit_cnt wraps to 0.
  - DATA, on the scl_fall after the 8th rise -> ACK. sda_oe <= ack_en, with ack_en sampled on that cycle.
  - ACK: hold sda_oe through the 9th SCL high.
    - On the next scl_fall: sda_oe <= 0, then -> DATA for the next byte (ACK and NACK both take this path).
  - START in any state: start_det pulse, -> DATA, bit_cnt=0, sda_oe=0, partial byte discarded. This covers repeated START mid-byte.
  - STOP in any state: stop_det pulse, -> IDLE, bit_cnt=0, sda_oe=0, partial byte discarded, data_out unchanged.
  - STOP while in IDLE: stop_det still pulses; state stays IDLE.
- Flow control: none.
  - data_out holds its value until the next completed byte.
  - data_valid is never asserted for a partial byte.
  - Its pulse width is exactly 1 clk regardless of the SCL period.
- Timing requirement: SCL high and low phases must each be at least SYNC_STAGES+3 clk periods.

Test Plan:
- START, then 0xA5 MSB first, ack_en=1 -> start_det pulse; data_valid pulse with data_out=0xA5 after the 8th SCL rise; sda_oe=1 from the 8th SCL fall to the 9th SCL fall, then 0.
- START, 0x3C, ack_en=0 -> data_out=0x3C, sda_oe stays 0 throughout the 9th bit; STOP -> stop_det pulse, busy=0.
- START, bytes 0x81 then 0x7E back-to-back with ACK, then STOP -> two data_valid pulses carrying 0x81 then 0x7E; busy high from START until the STOP response.
- START, 5 bits of 0xFF, then repeated START, then 0x12 -> no data_valid for the partial byte; second start_det pulse; data_out=0x12.
- START, 4 bits, then STOP -> stop_det pulse, state IDLE, data_out keeps its previous value, no data_valid.
- START, 0x55 through its ACK phase (sda_oe=1), then rst_n low for 2 clk -> sda_oe=0 and data_out=0 immediately; after release, a fresh START plus 0xC3 is received correctly.
